// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU inter-stage pipeline registers.
package pipe_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT    = 32'h1bfffffc;
    localparam int          STALL_CNT_W_DEFAULT = 16;
    localparam int          PC_W                = 32;

    // Bundle carried across a stage boundary at the default payload width.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     data;
    } stage_bundle_t;

endpackage

// File: rtl/skid_entry.sv
// Single-entry holding register with valid; parks one bundle while the main
// stage register is blocked downstream.
module skid_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              drain,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic              valid_nxt,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] data
);

    // A load in the same cycle as a drain refills the entry.
    always_comb begin
        valid_nxt = valid;
        if (flush)      valid_nxt = 1'b0;
        else if (load)  valid_nxt = 1'b1;
        else if (drain) valid_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            data  <= '0;
        end else begin
            valid <= valid_nxt;
            if (load && !flush) begin
                pc   <= in_pc;
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/allowin/ready_go handshake, flush,
// optional one-entry skid buffer and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter logic [PC_W-1:0]    PC_RESET   = PC_RESET_DEFAULT,
    parameter logic [DATA_W-1:0]  DATA_RESET = '0,
    parameter bit                 SKID       = 1'b0,
    parameter int                 CNT_W      = STALL_CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_allowin,
    input  logic              stage_ready_go,
    input  logic              next_allowin,
    output logic              out_valid,
    output logic              out_to_next_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              in_fire;
    logic              out_fire;
    logic              load_main;
    logic              from_skid;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_data;

    assign in_fire           = in_valid && out_allowin;
    assign out_fire          = out_valid && stage_ready_go && next_allowin;
    assign out_to_next_valid = out_valid && stage_ready_go;

    generate
        if (SKID) begin : g_skid
            logic skid_valid;
            logic skid_valid_nxt;
            logic skid_load;
            logic allowin_q;

            // Incoming bundle parks in skid when main is held, or when main
            // is being refilled from skid this cycle.
            assign skid_load = !flush && in_fire && out_valid && (!out_fire || skid_valid);
            assign from_skid = out_fire && skid_valid;

            skid_entry #(.DATA_W(DATA_W)) u_skid (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .load      (skid_load),
                .drain     (from_skid),
                .in_pc     (in_pc),
                .in_data   (in_data),
                .valid     (skid_valid),
                .valid_nxt (skid_valid_nxt),
                .pc        (skid_pc),
                .data      (skid_data)
            );

            // Registered copy of "skid will be empty" keeps allowin off the
            // downstream combinational path.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) allowin_q <= 1'b1;
                else     allowin_q <= !skid_valid_nxt;
            end

            assign out_allowin = allowin_q;
        end else begin : g_plain
            assign from_skid   = 1'b0;
            assign skid_pc     = '0;
            assign skid_data   = '0;
            assign out_allowin = !out_valid || (stage_ready_go && next_allowin);
        end
    endgenerate

    assign load_main = !flush && (from_skid || (in_fire && (!out_valid || out_fire)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= PC_RESET;
            out_data  <= DATA_RESET;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_main) begin
            out_valid <= 1'b1;
            out_pc    <= from_skid ? skid_pc   : in_pc;
            out_data  <= from_skid ? skid_data : in_data;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_fire && !flush && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

    // An unknown upstream valid must be caught, never read as a bundle.
    a_in_valid_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(in_valid));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboarded bench: a plain-register stage (4-bit counter) and a skid stage
// driven by identical stimulus, each modelled as a bounded FIFO.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        rg = 1'b1;
    logic        na = 1'b1;
    logic [31:0] in_pc = '0;
    logic [31:0] in_data = '0;

    logic [1:0]       alw, ov, otn;
    logic [1:0][31:0] opc, odat;
    logic [3:0]       sc0;
    logic [15:0]      sc1;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    stage_bundle_t sb[2][$];
    int mcnt[2] = '{0, 0};
    int cmax[2] = '{15, 65535};

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .SKID(1'b0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
        .in_data(in_data), .out_allowin(alw[0]), .stage_ready_go(rg), .next_allowin(na),
        .out_valid(ov[0]), .out_to_next_valid(otn[0]), .out_pc(opc[0]), .out_data(odat[0]),
        .stall_cnt(sc0)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
        .in_data(in_data), .out_allowin(alw[1]), .stage_ready_go(rg), .next_allowin(na),
        .out_valid(ov[1]), .out_to_next_valid(otn[1]), .out_pc(opc[1]), .out_data(odat[1]),
        .stall_cnt(sc1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Plain register takes a bundle if empty or draining; skid stage holds two.
    function automatic bit m_alw(int id, int n, bit r, bit a);
        return (id != 0) ? (n < 2) : (n == 0 || (r && a));
    endfunction

    // Monitor: compares live state against the FIFO model, pops on handoff.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            for (int id = 0; id < 2; id++) begin
                int n;
                bit mv;
                logic [63:0] scv;
                n   = sb[id].size();
                mv  = (n > 0);
                scv = (id != 0) ? 64'(sc1) : 64'(sc0);
                chk($sformatf("out_valid%0d", id), 64'(ov[id]), 64'(mv));
                chk($sformatf("allowin%0d", id), 64'(alw[id]), 64'(m_alw(id, n, rg, na)));
                chk($sformatf("to_next%0d", id), 64'(otn[id]), 64'(mv && rg));
                chk($sformatf("stall_cnt%0d", id), scv, 64'(mcnt[id]));
                if (mv) begin
                    chk($sformatf("out_pc%0d", id), 64'(opc[id]), 64'(sb[id][0].pc));
                    chk($sformatf("out_data%0d", id), 64'(odat[id]), 64'(sb[id][0].data));
                end
                if (!flush && mv && rg && na) void'(sb[id].pop_front());
                if (!flush && mv && !(rg && na) && mcnt[id] < cmax[id]) mcnt[id]++;
            end
        end
    end

    // Driver: one cycle of stimulus; expected bundles are pushed when accepted.
    task automatic cycle(input bit iv, input logic [31:0] pc, input logic [31:0] d,
                         input bit r, input bit a, input bit f);
        bit acc[2];
        @(negedge clk);
        in_valid = iv; in_pc = pc; in_data = d; rg = r; na = a; flush = f;
        #1;
        for (int id = 0; id < 2; id++) acc[id] = iv && !f && m_alw(id, sb[id].size(), r, a);
        #3;
        for (int id = 0; id < 2; id++) begin
            if (f) sb[id].delete();
            else if (acc[id]) sb[id].push_back('{pc: pc, data: d});
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; rg = 1'b1; na = 1'b1;
        in_pc = '0; in_data = '0;
        #1;
        for (int id = 0; id < 2; id++) begin
            chk($sformatf("rst_valid%0d", id), 64'(ov[id]), 64'd0);
            chk($sformatf("rst_pc%0d", id), 64'(opc[id]), 64'h1bfffffc);
            chk($sformatf("rst_data%0d", id), 64'(odat[id]), 64'd0);
            chk($sformatf("rst_allowin%0d", id), 64'(alw[id]), 64'd1);
            sb[id].delete();
            mcnt[id] = 0;
        end
        chk("rst_cnt0", 64'(sc0), 64'd0);
        chk("rst_cnt1", 64'(sc1), 64'd0);
        #1 rst = 1'b0;
        #1 mon_en = 1'b1;
    endtask

    initial begin
        do_reset();

        // Streaming then a three-cycle stall on 0x1c000010.
        cycle(1, 32'h1c000000, 32'h11, 1, 1, 0);
        cycle(1, 32'h1c000004, 32'h22, 1, 1, 0);
        cycle(1, 32'h1c000008, 32'h33, 1, 1, 0);
        cycle(1, 32'h1c000010, 32'h44, 1, 1, 0);
        repeat (3) cycle(0, 32'h0, 32'h0, 0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 1, 0);
        chk("stall3_cnt0", 64'(sc0), 64'd3);
        chk("stall3_cnt1", 64'(sc1), 64'd3);
        chk("stall3_pc0", 64'(opc[0]), 64'h1c000010);

        // Skid capture while downstream blocks, then in-order release.
        cycle(1, 32'h100, 32'haa, 1, 1, 0);
        cycle(1, 32'h104, 32'hbb, 1, 0, 0);
        cycle(0, 32'h0, 32'h0, 1, 0, 0);
        chk("skid_allowin1", 64'(alw[1]), 64'd0);
        chk("skid_pc1", 64'(opc[1]), 64'h100);
        cycle(1, 32'h108, 32'hcc, 1, 1, 0);
        cycle(1, 32'h10c, 32'hdd, 1, 1, 0);
        repeat (3) cycle(0, 32'h0, 32'h0, 1, 1, 0);

        // Flush with main and skid full and a bundle arriving.
        cycle(1, 32'h200, 32'h1, 1, 0, 0);
        cycle(1, 32'h204, 32'h2, 1, 0, 0);
        cycle(1, 32'h208, 32'h3, 1, 0, 1);
        cycle(0, 32'h0, 32'h0, 1, 1, 0);
        chk("flush_valid0", 64'(ov[0]), 64'd0);
        chk("flush_valid1", 64'(ov[1]), 64'd0);
        chk("flush_allowin1", 64'(alw[1]), 64'd1);
        cycle(1, 32'h20c, 32'h4, 1, 0, 0);
        cycle(0, 32'h0, 32'h0, 1, 1, 0);
        chk("flush_next_pc1", 64'(opc[1]), 64'h20c);
        cycle(0, 32'h0, 32'h0, 1, 1, 0);

        // Randomised traffic with occasional flushes.
        repeat (3000)
            cycle(($urandom % 4) != 0, $urandom & 32'hfffffffc, $urandom,
                  ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0);

        // Counter saturation, then asynchronous reset in the middle of a stall.
        do_reset();
        cycle(1, 32'h300, 32'h5, 1, 1, 0);
        repeat (20) cycle(0, 32'h0, 32'h0, 0, 1, 0);
        chk("sat_cnt0", 64'(sc0), 64'd15);
        chk("sat_cnt1", 64'(sc1), 64'd19);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_cnt0", 64'(sc0), 64'd0);
        chk("arst_cnt1", 64'(sc1), 64'd0);
        chk("arst_valid0", 64'(ov[0]), 64'd0);
        chk("arst_valid1", 64'(ov[1]), 64'd0);
        do_reset();
        repeat (2) cycle(0, 32'h0, 32'h0, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
